// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with 2-entry skid buffer, flush and bubbles
// Optional stall/flush performance counters enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic push;
    logic main_free;

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally
    assign in_ready  = ~skid_valid;
    assign push      = in_valid & in_ready;
    assign main_free = ~main_valid | out_ready;

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            // Data registers keep stale contents; zeroed ctrl makes them bubbles
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
                skid_ctrl  <= '0;
            end else if (push) begin
                main_valid <= 1'b1;
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
                main_ctrl  <= '0;
            end
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (main_valid || skid_valid) && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] ic;
        logic [7:0] id;
        logic       ordy;
        logic       fl;
        logic       ov;
        logic [7:0] oc;
        logic [7:0] od;
        logic       irdy;
        logic [1:0] occ;
    } vec_t;

    vec_t vecs[17];

    int checks = 0;
    int fails  = 0;
    logic [CTRL_W+DATA_W-1:0] sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, update scoreboard from pre-edge handshake, step past posedge
    task automatic cyc(input logic iv, input logic [7:0] ic, input logic [7:0] id,
                       input logic ordy, input logic fl);
        logic [CTRL_W+DATA_W-1:0] front;
        @(negedge clk);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = {56'd0, id};
        out_ready = ordy;
        flush     = fl;
        #1;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_pop", 64'd1, 64'd0);
            end else begin
                front = sb_q.pop_front();
                check("sb_pop_data", out_data, front[DATA_W-1:0]);
                check("sb_pop_ctrl", {56'd0, out_ctrl}, {56'd0, front[CTRL_W+DATA_W-1:DATA_W]});
            end
        end
        if (fl)
            sb_q.delete();
        else if (iv && in_ready)
            sb_q.push_back({ic, {56'd0, id}});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // streaming
        vecs[0]  = '{1, 8'h01, 8'h01, 1, 0,  1, 8'h01, 8'h01, 1, 1};
        vecs[1]  = '{1, 8'h02, 8'h02, 1, 0,  1, 8'h02, 8'h02, 1, 1};
        vecs[2]  = '{1, 8'h03, 8'h03, 1, 0,  1, 8'h03, 8'h03, 1, 1};
        vecs[3]  = '{1, 8'h04, 8'h04, 1, 0,  1, 8'h04, 8'h04, 1, 1};
        vecs[4]  = '{0, 8'h00, 8'h00, 1, 0,  0, 8'h00, 8'h00, 1, 0};
        // backpressure, third offer refused while full
        vecs[5]  = '{1, 8'hA1, 8'h11, 0, 0,  1, 8'hA1, 8'h11, 1, 1};
        vecs[6]  = '{1, 8'hA2, 8'h22, 0, 0,  1, 8'hA1, 8'h11, 0, 2};
        vecs[7]  = '{1, 8'hA3, 8'h99, 0, 0,  1, 8'hA1, 8'h11, 0, 2};
        vecs[8]  = '{0, 8'h00, 8'h00, 1, 0,  1, 8'hA2, 8'h22, 1, 1};
        vecs[9]  = '{0, 8'h00, 8'h00, 1, 0,  0, 8'h00, 8'h00, 1, 0};
        // flush while full, offered C=0x33 discarded
        vecs[10] = '{1, 8'h5A, 8'h44, 0, 0,  1, 8'h5A, 8'h44, 1, 1};
        vecs[11] = '{1, 8'h5A, 8'h55, 0, 0,  1, 8'h5A, 8'h44, 0, 2};
        vecs[12] = '{1, 8'h5A, 8'h33, 0, 1,  0, 8'h00, 8'h00, 1, 0};
        vecs[13] = '{0, 8'h00, 8'h00, 1, 0,  0, 8'h00, 8'h00, 1, 0};
        // flush with simultaneous pop
        vecs[14] = '{1, 8'h66, 8'h66, 0, 0,  1, 8'h66, 8'h66, 1, 1};
        vecs[15] = '{0, 8'h00, 8'h00, 1, 1,  0, 8'h00, 8'h00, 1, 0};
        vecs[16] = '{0, 8'h00, 8'h00, 1, 0,  0, 8'h00, 8'h00, 1, 0};

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'hFF; in_data = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_occupancy", {62'd0, occupancy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_occupancy", {62'd0, occupancy}, 64'd0);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].iv, vecs[i].ic, vecs[i].id, vecs[i].ordy, vecs[i].fl);
            check($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].ov});
            check($sformatf("v%0d_out_ctrl", i), {56'd0, out_ctrl}, {56'd0, vecs[i].oc});
            if (vecs[i].ov)
                check($sformatf("v%0d_out_data", i), out_data, {56'd0, vecs[i].od});
            check($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].irdy});
            check($sformatf("v%0d_occupancy", i), {62'd0, occupancy}, {62'd0, vecs[i].occ});
        end
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        // async reset in the middle of a stall with both entries held
        cyc(1, 8'h77, 8'h77, 0, 0);
        cyc(1, 8'h78, 8'h78, 0, 0);
        check("full_before_rst", {62'd0, occupancy}, 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        check("arst_out_data", out_data, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_occupancy", {62'd0, occupancy}, 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
        cyc(1, 8'h10, 8'h10, 0, 0);
        repeat (5) cyc(0, 8'h00, 8'h00, 0, 0);
        cyc(0, 8'h00, 8'h00, 1, 1);
        cyc(0, 8'h00, 8'h00, 1, 1);
        check("perf_stall_cnt", 64'(stall_cnt), 64'd5);
        check("perf_flush_cnt", 64'(flush_cnt), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data field between two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure needs no combinational ready path.
- Synchronous flush kills in-flight entries and zeroes their control bits, turning them into bubbles.

Parameters:
- DATA_W, 64: width of the payload field (operands, immediate, PC, register indices, packed by the instantiating stage).
- CTRL_W, 8: width of the control field (reg_write, mem_read, mem_write, branch, etc.); zeroed on flush and on bubbles.
- CNT_W, 32: width of the performance counters; used only with PIPE_STAGE_PERF_EN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries (mispredict, exception)
- in_valid  in  1  upstream presents an entry
- in_ready  out  1  stage can accept; registered, equal to ~skid_valid
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream consumes out entry this cycle
- out_ctrl  out  CTRL_W  main control field; forced to 0 when out_valid=0
- out_data  out  DATA_W  main payload (not gated)
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  (PIPE_STAGE_PERF_EN only) cycles with out_valid & ~out_ready
- flush_cnt  out  CNT_W  (PIPE_STAGE_PERF_EN only) flushes that killed ≥1 valid entry

Behaviour:
- Reset (rst_n=0, async assert, sync-released by the top level):
  - main_valid=0, skid_valid=0, all ctrl/data registers 0.
  - in_ready=1, out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - Counters cleared.
  - Reset mid-transfer discards all entries with no partial update.
- Definitions:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
- Latency: an entry pushed in cycle N is on out_* in cycle N+1 when the stage is EMPTY, or ONE with a pop.
- Ordering is strict FIFO; the skid entry always moves to main before any newer entry.
- States (occupancy):
  - EMPTY:
    - push -> ONE, main<=in.
    - Otherwise stay in EMPTY.
  - ONE:
    - push & pop -> ONE, main<=in.
    - push & ~pop -> TWO, skid<=in.
    - ~push & pop -> EMPTY.
    - Neither -> ONE, hold.
  - TWO (in_ready=0, so push is impossible):
    - pop -> ONE, main<=skid, skid cleared.
    - ~pop -> TWO, hold.
- Stall: while out_valid & ~out_ready, out_ctrl and out_data stay bit-stable.
- Flush (priority below reset, above everything else):
  - Next cycle: main_valid=0, skid_valid=0, ctrl registers of both entries =0, occupancy=0, in_ready=1.
  - An input offered in the flush cycle is discarded even if in_ready=1.
  - A pop in the same cycle as flush still completes: downstream sampled it.
  - Data registers may keep stale values; out_ctrl=0 makes them harmless.
- Bubble: whenever out_valid=0, out_ctrl reads all-zero, so downstream decodes a NOP without checking valid.
- in_ready depends only on registers; there is no combinational path from out_ready to in_ready.
- occupancy = main_valid + skid_valid; the value 3 never occurs.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & ~out_ready.
  - flush_cnt increments on each flush cycle where occupancy≠0.
  - Both saturate at all-ones and clear on reset.
- Undefined: stall_cnt and flush_cnt ports and all counter logic are absent; the remaining behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, in_ctrl=8'hFF -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0; still 0 one cycle after release with in_valid=0.
- Streaming: out_ready=1, push data 1,2,3,4 in consecutive cycles -> out_data 1,2,3,4 one cycle later each, occupancy=1 throughout, in_ready never drops.
- Backpressure: out_ready=0, push A=0x11 then B=0x22 -> occupancy=2, in_ready=0, out_data=0x11 stable; raise out_ready -> 0x11 then 0x22 on consecutive cycles, in_ready=1 after the first pop.
- Flush with stage full: occupancy=2, ctrl=8'h5A, assert flush with in_valid=1, C=0x33 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; C never appears at the output.
- Flush + pop same cycle: occupancy=1, out_ready=1, flush=1 -> entry counted as consumed, then EMPTY; the async reset pulse mid-stall clears everything within the same cycle.
- Perf (PIPE_STAGE_PERF_EN): 5 stall cycles, then 1 flush with occupancy=1, then 1 flush with occupancy=0 -> stall_cnt=5, flush_cnt=1.
